// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Round-robin two-client arbiter in front of one SDRAM core port.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_wr,
    input  logic                  a_rd,
    input  logic [DATA_WIDTH-1:0] a_write_data,
    output logic                  a_rdy,
    output logic                  a_wvalid,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_read_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_wr,
    input  logic                  b_rd,
    input  logic [DATA_WIDTH-1:0] b_write_data,
    output logic                  b_rdy,
    output logic                  b_wvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_read_data,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic [DATA_WIDTH-1:0] ctrl_write_data,
    output logic                  ctrl_wr,
    output logic                  ctrl_rd,
    input  logic                  ctrl_rdy,
    input  logic                  ctrl_wvalid,
    input  logic                  ctrl_rvalid,
    input  logic [DATA_WIDTH-1:0] ctrl_read_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_A = 3'd1,
        S_GRANT_B = 3'd2,
        S_WAIT_A  = 3'd3,
        S_WAIT_B  = 3'd4
    } state_t;

    localparam logic c_portA = 1'b0;
    localparam logic c_portB = 1'b1;

    state_t r_state;
    state_t w_nextState;
    logic   r_last;
    logic   w_nextLast;
    logic   r_opWr;
    logic   w_nextOpWr;
    logic   w_reqA;
    logic   w_reqB;
    logic   w_doneA;
    logic   w_doneB;

    assign w_reqA  = a_wr | a_rd;
    assign w_reqB  = b_wr | b_rd;
    assign w_doneA = r_opWr ? ctrl_wvalid : ctrl_rvalid;
    assign w_doneB = w_doneA;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_last  <= c_portB;
            r_opWr  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_last  <= w_nextLast;
            r_opWr  <= w_nextOpWr;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextLast      = r_last;
        w_nextOpWr      = r_opWr;
        ctrl_addr       = '0;
        ctrl_write_data = '0;
        ctrl_wr         = 1'b0;
        ctrl_rd         = 1'b0;
        a_rdy           = 1'b0;
        a_wvalid        = 1'b0;
        a_rvalid        = 1'b0;
        a_read_data     = '0;
        b_rdy           = 1'b0;
        b_wvalid        = 1'b0;
        b_rvalid        = 1'b0;
        b_read_data     = '0;
        case (r_state)
            S_IDLE: begin
                // On a tie the port not served most recently wins
                if (w_reqA && w_reqB) begin
                    w_nextState = (r_last == c_portB) ? S_GRANT_A : S_GRANT_B;
                end else if (w_reqA) begin
                    w_nextState = S_GRANT_A;
                end else if (w_reqB) begin
                    w_nextState = S_GRANT_B;
                end
            end
            S_GRANT_A: begin
                ctrl_addr       = a_addr;
                ctrl_write_data = a_write_data;
                ctrl_wr         = a_wr;
                ctrl_rd         = a_rd & ~a_wr;
                a_rdy           = ctrl_rdy;
                if (!w_reqA) begin
                    w_nextState = S_IDLE;
                end else if (ctrl_rdy) begin
                    w_nextState = S_WAIT_A;
                    w_nextOpWr  = a_wr;
                end
            end
            S_GRANT_B: begin
                ctrl_addr       = b_addr;
                ctrl_write_data = b_write_data;
                ctrl_wr         = b_wr;
                ctrl_rd         = b_rd & ~b_wr;
                b_rdy           = ctrl_rdy;
                if (!w_reqB) begin
                    w_nextState = S_IDLE;
                end else if (ctrl_rdy) begin
                    w_nextState = S_WAIT_B;
                    w_nextOpWr  = b_wr;
                end
            end
            S_WAIT_A: begin
                a_wvalid = r_opWr & ctrl_wvalid;
                a_rvalid = ~r_opWr & ctrl_rvalid;
                if (!r_opWr) begin
                    a_read_data = ctrl_read_data;
                end
                if (w_doneA) begin
                    w_nextState = S_IDLE;
                    w_nextLast  = c_portA;
                end
            end
            S_WAIT_B: begin
                b_wvalid = r_opWr & ctrl_wvalid;
                b_rvalid = ~r_opWr & ctrl_rvalid;
                if (!r_opWr) begin
                    b_read_data = ctrl_read_data;
                end
                if (w_doneB) begin
                    w_nextState = S_IDLE;
                    w_nextLast  = c_portB;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Directed and random checks of sdram_arbiter against an
//            ownership/transaction level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, b_addr, a_write_data, b_write_data;
    logic        a_wr, a_rd, b_wr, b_rd;
    logic        a_rdy, a_wvalid, a_rvalid, b_rdy, b_wvalid, b_rvalid;
    logic [31:0] a_read_data, b_read_data;
    logic [31:0] ctrl_addr, ctrl_write_data, ctrl_read_data;
    logic        ctrl_wr, ctrl_rd, ctrl_rdy, ctrl_wvalid, ctrl_rvalid;

    sdram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_wr(a_wr), .a_rd(a_rd), .a_write_data(a_write_data),
        .a_rdy(a_rdy), .a_wvalid(a_wvalid), .a_rvalid(a_rvalid), .a_read_data(a_read_data),
        .b_addr(b_addr), .b_wr(b_wr), .b_rd(b_rd), .b_write_data(b_write_data),
        .b_rdy(b_rdy), .b_wvalid(b_wvalid), .b_rvalid(b_rvalid), .b_read_data(b_read_data),
        .ctrl_addr(ctrl_addr), .ctrl_write_data(ctrl_write_data),
        .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_rdy(ctrl_rdy),
        .ctrl_wvalid(ctrl_wvalid), .ctrl_rvalid(ctrl_rvalid), .ctrl_read_data(ctrl_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the core (0 none, 1 A, 2 B), whether its request was
    // accepted, what kind it was, and who finished most recently.
    int          owner = 0;
    bit          accepted = 1'b0;
    bit          pendWrite = 1'b0;
    bit          lastWasB = 1'b1;
    logic [31:0] mem [logic [31:0]];
    int          grantLog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
        ctrl_rdy = 0; ctrl_wvalid = 0; ctrl_rvalid = 0;
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [31:0] eAddr, eData, eRdA, eRdB, xAddr, xData;
        logic        eWr, eRd, eRdyA, eRdyB, eWvA, eWvB, eRvA, eRvB, xWr, xRd, wv, rv;
        logic        reqA, reqB;
        @(negedge clk);
        {eAddr, eData, eRdA, eRdB} = '0;
        {eWr, eRd, eRdyA, eRdyB, eWvA, eWvB, eRvA, eRvB} = '0;
        xWr   = (owner == 1) ? a_wr : b_wr;
        xRd   = (owner == 1) ? a_rd : b_rd;
        xAddr = (owner == 1) ? a_addr : b_addr;
        xData = (owner == 1) ? a_write_data : b_write_data;
        if (owner != 0 && !accepted) begin
            eAddr = xAddr; eData = xData; eWr = xWr; eRd = xRd & ~xWr;
            if (owner == 1) eRdyA = ctrl_rdy; else eRdyB = ctrl_rdy;
        end else if (owner != 0) begin
            wv = pendWrite & ctrl_wvalid;
            rv = ~pendWrite & ctrl_rvalid;
            if (owner == 1) begin
                eWvA = wv; eRvA = rv; eRdA = pendWrite ? 32'h0 : ctrl_read_data;
            end else begin
                eWvB = wv; eRvB = rv; eRdB = pendWrite ? 32'h0 : ctrl_read_data;
            end
        end
        check("ctrl_addr", ctrl_addr, eAddr);
        check("ctrl_write_data", ctrl_write_data, eData);
        check("ctrl_wr", {31'b0, ctrl_wr}, {31'b0, eWr});
        check("ctrl_rd", {31'b0, ctrl_rd}, {31'b0, eRd});
        check("a_rdy", {31'b0, a_rdy}, {31'b0, eRdyA});
        check("b_rdy", {31'b0, b_rdy}, {31'b0, eRdyB});
        check("a_wvalid", {31'b0, a_wvalid}, {31'b0, eWvA});
        check("b_wvalid", {31'b0, b_wvalid}, {31'b0, eWvB});
        check("a_rvalid", {31'b0, a_rvalid}, {31'b0, eRvA});
        check("b_rvalid", {31'b0, b_rvalid}, {31'b0, eRvB});
        check("a_read_data", a_read_data, eRdA);
        check("b_read_data", b_read_data, eRdB);
        if (a_rdy === 1'b1) grantLog.push_back(1);
        if (b_rdy === 1'b1) grantLog.push_back(2);
        @(posedge clk);
        reqA = a_wr | a_rd;
        reqB = b_wr | b_rd;
        if (!rst) begin
            owner = 0; accepted = 0; lastWasB = 1;
        end else if (owner == 0) begin
            if (reqA && reqB) owner = lastWasB ? 1 : 2;
            else if (reqA) owner = 1;
            else if (reqB) owner = 2;
        end else if (!accepted) begin
            if (!(xWr | xRd)) begin
                owner = 0;
            end else if (ctrl_rdy) begin
                accepted = 1; pendWrite = xWr;
                if (xWr) mem[xAddr] = xData;
            end
        end else if (pendWrite ? ctrl_wvalid : ctrl_rvalid) begin
            lastWasB = (owner == 2); owner = 0; accepted = 0;
        end
        #1;
    endtask

    initial begin
        int expOrder[4];
        rst = 0;
        a_addr = 0; b_addr = 0; a_write_data = 0; b_write_data = 0; ctrl_read_data = 0;
        clearInputs();
        @(posedge clk); #1;
        step();
        rst = 1;
        step();

        // A write to 0x12345678
        a_addr = 32'h1234_5678; a_write_data = 32'hDEAD_BEEF; a_wr = 1;
        step(); step();
        ctrl_rdy = 1; step();
        a_wr = 0; ctrl_rdy = 0; step();
        ctrl_wvalid = 1; step();
        ctrl_wvalid = 0; step();

        // Read it back on A
        a_rd = 1; step();
        ctrl_rdy = 1; step();
        a_rd = 0; ctrl_rdy = 0; step();
        ctrl_rvalid = 1; ctrl_read_data = mem[32'h1234_5678];
        #1;
        check("readback_a", a_read_data, 32'hDEAD_BEEF);
        check("readback_b_zero", b_read_data, 32'h0);
        step();
        ctrl_rvalid = 0; step();

        // Continuous contention after reset: A, B, A, B
        rst = 0; step(); rst = 1;
        a_addr = 32'hA0; b_addr = 32'hB0; a_wr = 1; b_wr = 1; ctrl_rdy = 1;
        grantLog.delete();
        for (int i = 0; i < 12; i++) begin
            ctrl_wvalid = (owner != 0 && accepted) ? 1'b1 : 1'b0;
            step();
        end
        clearInputs(); step();
        expOrder = '{1, 2, 1, 2};
        check("grant_count", grantLog.size(), 4);
        for (int i = 0; i < 4 && i < grantLog.size(); i++)
            check("grant_order", grantLog[i], expOrder[i]);

        // B read outstanding while A asks to write
        b_rd = 1; ctrl_rdy = 1; step(); step();
        b_rd = 0; a_wr = 1; step(); step(); step();
        ctrl_rvalid = 1; ctrl_read_data = 32'h5A5A_0001; step();
        ctrl_rvalid = 0; step(); step();
        a_wr = 0; ctrl_rdy = 0; ctrl_wvalid = 1; step();
        clearInputs(); step();

        // A with wr and rd together; spurious rvalid ignored
        a_wr = 1; a_rd = 1; step(); step();
        ctrl_rdy = 1; step();
        clearInputs(); ctrl_rvalid = 1; step();
        ctrl_rvalid = 0; ctrl_wvalid = 1; step();
        clearInputs(); step();

        // Reset during WAIT_A, late completion dropped, B then served
        a_wr = 1; ctrl_rdy = 1; step(); step();
        clearInputs(); step();
        rst = 0; step();
        rst = 1; step();
        ctrl_wvalid = 1; step();
        clearInputs(); b_wr = 1; b_addr = 32'hB4; ctrl_rdy = 1; step(); step();
        b_wr = 0; ctrl_rdy = 0; ctrl_wvalid = 1; step();
        clearInputs(); step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 49) != 0);
            a_wr           = ($urandom_range(0, 2) == 0);
            a_rd           = ($urandom_range(0, 2) == 0);
            b_wr           = ($urandom_range(0, 2) == 0);
            b_rd           = ($urandom_range(0, 2) == 0);
            a_addr         = $urandom; b_addr = $urandom;
            a_write_data   = $urandom; b_write_data = $urandom;
            ctrl_rdy       = ($urandom_range(0, 1) == 0);
            ctrl_wvalid    = ($urandom_range(0, 3) == 0);
            ctrl_rvalid    = ($urandom_range(0, 3) == 0);
            ctrl_read_data = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
